// File: rtl/irq_pending_arbiter.sv
// Sticky interrupt-pending capture with enable mask, fixed-priority selection
// (highest-numbered line wins) and a valid/ready index offer to the encoder stage.
module irq_pending_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = 2,
  parameter int EDGE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic [N-1:0]    mask,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    pending
);

  // Handshake: an offer is open while out_valid=1; out_idx is stable for its
  // whole life and it completes on the first rising edge with out_ready=1.
  // out_ready is ignored while out_valid=0.
  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    req_q, req_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;

  logic [N-1:0]    evt;
  logic [N-1:0]    clr;
  logic [N-1:0]    elig;
  logic [IDXW-1:0] sel_idx;
  logic            handshake;

  always_comb begin
    evt       = (EDGE != 0) ? (req_in & ~req_q) : req_in;
    handshake = (state_q == OFFER) && out_ready;
    clr       = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = handshake && (out_idx_q == IDXW'(i));
    end

    // Ascending scan: the last hit is the highest-numbered eligible line.
    elig    = pending_q & mask;
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        sel_idx = IDXW'(i);
      end
    end

    // A new event on the served line in the handshake cycle survives the clear.
    state_d   = state_q;
    out_idx_d = out_idx_q;
    pending_d = (pending_q & ~clr) | evt;
    req_d     = req_in;

    case (state_q)
      IDLE: begin
        if (elig != '0) begin
          state_d   = OFFER;
          out_idx_d = sel_idx;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      pending_d = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      req_q     <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_valid = (state_q == OFFER);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Drives an edge-capture and a level-capture instance with identical stimulus and
// compares both against a transaction-level model of pending/offer behaviour.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in, mask;
  logic       flush, out_ready;
  logic       valid_e, valid_l;
  logic [1:0] idx_e, idx_l;
  logic [3:0] pend_e, pend_l;

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = edge instance, 1 = level instance.
  logic [3:0] m_pend[2];
  logic       m_val[2];
  logic [1:0] m_idx[2];
  logic [3:0] m_prev[2];

  always #5 clk = ~clk;

  irq_pending_arbiter #(.N(4), .IDXW(2), .EDGE(1)) u_dut_edge (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .flush(flush),
    .out_valid(valid_e), .out_ready(out_ready), .out_idx(idx_e), .pending(pend_e)
  );

  irq_pending_arbiter #(.N(4), .IDXW(2), .EDGE(0)) u_dut_level (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .flush(flush),
    .out_valid(valid_l), .out_ready(out_ready), .out_idx(idx_l), .pending(pend_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0; m_val[k] = 1'b0; m_idx[k] = '0; m_prev[k] = '0;
    end
  endfunction

  // One clock of behaviour: an open offer either completes or waits; an idle
  // arbiter picks the highest eligible line from the pending set it already holds.
  function automatic void model_step(input int k);
    logic [3:0] ev;
    int         e;
    ev = (k == 0) ? (req_in & ~m_prev[k]) : req_in;
    if (flush) begin
      m_pend[k] = '0;
      m_val[k]  = 1'b0;
    end else if (m_val[k]) begin
      if (out_ready) begin
        m_pend[k][m_idx[k]] = 1'b0;
        m_val[k] = 1'b0;
      end
      m_pend[k] = m_pend[k] | ev;
    end else begin
      e = int'(m_pend[k] & mask);
      if (e != 0) begin
        m_val[k] = 1'b1;
        m_idx[k] = 2'($clog2(e + 1) - 1);
      end
      m_pend[k] = m_pend[k] | ev;
    end
    m_prev[k] = req_in;
  endfunction

  task automatic compare_all();
    check("edge_valid", 32'(valid_e), 32'(m_val[0]));
    check("edge_pending", 32'(pend_e), 32'(m_pend[0]));
    if (m_val[0]) check("edge_idx", 32'(idx_e), 32'(m_idx[0]));
    check("level_valid", 32'(valid_l), 32'(m_val[1]));
    check("level_pending", 32'(pend_l), 32'(m_pend[1]));
    if (m_val[1]) check("level_idx", 32'(idx_l), 32'(m_idx[1]));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] m, input logic f, input logic rdy);
    req_in = r; mask = m; flush = f; out_ready = rdy;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic clean();
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
  endtask

  int n_off_e, n_off_l;

  initial begin
    rst_n = 1'b0; req_in = '0; mask = 4'b1111; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(valid_e), 32'd0);
    check("rst_idx", 32'(idx_e), 32'd0);
    check("rst_pending", 32'(pend_e), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single event on line 1
    step(4'b0010, 4'b1111, 1'b0, 1'b1);
    check("s1_pend_c1", 32'(pend_e), 32'h2);
    check("s1_valid_c1", 32'(valid_e), 32'd0);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s1_valid_c2", 32'(valid_e), 32'd1);
    check("s1_idx_c2", 32'(idx_e), 32'd1);
    check("s1_pend_c2", 32'(pend_e), 32'h2);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s1_valid_c3", 32'(valid_e), 32'd0);
    check("s1_pend_c3", 32'(pend_e), 32'h0);
    clean();

    // Simultaneous events on 0, 2, 3: offers 3, 2, 0 with idle gaps
    step(4'b1101, 4'b1111, 1'b0, 1'b1);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s2_first", 32'(idx_e), 32'd3);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s2_gap1", 32'(valid_e), 32'd0);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s2_second", 32'(idx_e), 32'd2);
    repeat (2) step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s2_third", 32'(idx_e), 32'd0);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    check("s2_pend_end", 32'(pend_e), 32'h0);
    clean();

    // Line 0 held offered; line 3 arrives and line 0 is masked off
    step(4'b0001, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b1000, 4'b1110, 1'b0, 1'b0);
    step(4'b0000, 4'b1110, 1'b0, 1'b0);
    check("s3_hold_valid", 32'(valid_e), 32'd1);
    check("s3_hold_idx", 32'(idx_e), 32'd0);
    step(4'b0000, 4'b1110, 1'b0, 1'b1);
    step(4'b0000, 4'b1110, 1'b0, 1'b1);
    check("s3_next_idx", 32'(idx_e), 32'd3);
    clean();

    // All masked: accumulate, then enable line 2 only
    repeat (3) step(4'b1111, 4'b0000, 1'b0, 1'b1);
    check("s4_no_offer", 32'(valid_e), 32'd0);
    check("s4_pend_all", 32'(pend_e), 32'hf);
    step(4'b1111, 4'b0100, 1'b0, 1'b1);
    check("s4_offer_idx", 32'(idx_e), 32'd2);
    step(4'b1111, 4'b0100, 1'b0, 1'b1);
    step(4'b1111, 4'b0100, 1'b0, 1'b1);
    check("s4_pend_after", 32'(pend_e), 32'hb);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);

    // Line 2 held high across handshakes: edge offers once, level re-offers
    n_off_e = 0; n_off_l = 0;
    for (int c = 0; c < 10; c++) begin
      step(4'b0100, 4'b1111, 1'b0, 1'b1);
      if (valid_e) n_off_e++;
      if (valid_l) n_off_l++;
    end
    check("s5_edge_once", 32'(n_off_e), 32'd1);
    check("s5_level_reoffer", 32'(n_off_l >= 2), 32'd1);
    clean();

    // Flush during an offer with a same-cycle line-1 event
    step(4'b0001, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b0010, 4'b1111, 1'b1, 1'b1);
    check("s6_valid", 32'(valid_e), 32'd0);
    check("s6_pend", 32'(pend_e), 32'h0);
    n_off_e = 0;
    for (int c = 0; c < 4; c++) begin
      step(4'b0000, 4'b1111, 1'b0, 1'b1);
      if (valid_e) n_off_e++;
    end
    check("s6_no_offer", 32'(n_off_e), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111,
           ($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of an open offer
    clean();
    step(4'b0100, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    check("mid_rst_pre", 32'(valid_e), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid_e", 32'(valid_e), 32'd0);
    check("mid_rst_valid_l", 32'(valid_l), 32'd0);
    check("mid_rst_pend", 32'(pend_e), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step(4'b0000, 4'b1111, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
Name: irq_pending_arbiter

Overview:
- Sequential front end for the fixed-priority encoder stage.
- Captures request events into sticky pending bits and applies a per-line enable mask.
- Selects the highest-numbered eligible line and offers its index downstream over a valid/ready handshake.
- Clears the served pending bit when the handshake completes. The code mapping matches the encoder convention: line 3 -> 2'b11, line 2 -> 2'b10, line 1 -> 2'b01, line 0 -> 2'b00.

Parameters:
- N, 4, number of request lines (2..16).
- IDXW, 2, index width; must equal clog2(N).
- EDGE, 1, 1 = rising-edge capture of req_in, 0 = level capture (a held line re-pends after service).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  raw request lines, synchronous to clk.
- mask  input  N  1 = line enabled for selection; pending capture ignores mask.
- flush  input  1  synchronous clear of all pending state and any open offer.
- out_valid  output  1  index offer valid.
- out_ready  input  1  consumer accepts the offer.
- out_idx  output  IDXW  index of the offered line.
- pending  output  N  current sticky pending bits, registered.

Behaviour:
- Reset (rst_n=0, async): pending=0, out_valid=0, out_idx=0, req_q=0, state=IDLE. Outputs stay at these values until the first clk edge after rst_n rises.
- Event detect:
  - EDGE=1: event = req_in & ~req_q.
  - EDGE=0: event = req_in.
  - req_q <= req_in every cycle.
- Pending update: pending <= (pending & ~clr) | event.
  - clr = one-hot of out_idx when out_valid && out_ready, else 0.
  - A new event on the served bit in the handshake cycle wins (bit stays set).
- Eligibility: elig = pending & mask. Select the highest set bit of elig (bit N-1 highest priority).
- FSM states:
  - IDLE: out_valid=0. If elig != 0, register out_idx = selected index, set out_valid=1, go to OFFER. Otherwise stay.
  - OFFER: out_valid=1. out_idx is held stable; no preemption by higher-priority events, and no withdrawal if the line is later masked. On out_valid && out_ready: clear pending[out_idx], out_valid=0 next cycle, go to IDLE.
- Throughput: at least one IDLE cycle between consecutive offers, so maximum throughput is 1 index per 2 cycles.
- Latency: req_in rises in cycle t -> pending bit set at edge ending t -> out_valid high from cycle t+2 (IDLE evaluates at t+1).
- flush=1: at the next edge pending=0, out_valid=0, state=IDLE, and same-cycle events are dropped. A handshake in the flush cycle counts as accepted by the consumer but has no further effect. req_q still updates.
- mask=0 on all lines: pending keeps accumulating and no offer is made. Unmasking a line makes it eligible in the next IDLE evaluation.
- out_ready while out_valid=0 is ignored.
- Reset mid-offer: immediate out_valid=0; the offer is lost.

Test Plan:
- Reset, then a single event on line 1 (req_in 0000 -> 0010 at cycle 0), out_ready=1 → out_valid=1 at cycle 2 with out_idx=01 and pending=0010; at cycle 3 out_valid=0 and pending=0000.
- Simultaneous events on lines 0, 2 and 3 (req_in=1101), out_ready=1 → three offers in order idx 11, 10, 00, each separated by one idle cycle; pending ends 0000.
- Line 0 offered with out_ready=0, then a line-3 event and mask[0] cleared → out_idx stays 00 with out_valid held; after out_ready=1, the next offer is idx 11.
- mask=0000 with req_in=1111 → no offer and pending=1111; set mask=0100 → offer idx 10 within 2 cycles; pending becomes 1011 after accept.
- EDGE=1, line 2 held high across a handshake → exactly one offer. EDGE=0, same stimulus → line 2 re-pends and is re-offered.
- flush asserted during OFFER with a same-cycle line-1 event → next cycle out_valid=0, pending=0000, and no subsequent offer.
